decode_regfile_stage: RTL
=========================

Name: decode_regfile_stage

Overview:
Parametrised decode stage for the multi-cycle MIPS core, and the successor of the fixed 32-bit decoder. It parses a fetched instruction, generates the control bundle and reads two operands from an internal 2-read/1-write register file. It has a valid/ready handshake on both sides, a write-back port with same-cycle forwarding, load-use stall detection and a sticky end-of-program flag. It sits between fetch and execute, and replaces the stage==1 gating with the handshake.

Parameters:
DATA_W, 32, operand/immediate/register width (>=16)
NUM_REGS, 32, register count (power of two, <=32)
AW, $clog2(NUM_REGS), register address width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low
in_valid  in  1  instruction offered by fetch
in_ready  out  1  stage accepts the instruction this cycle
in_instr  in  32  MIPS instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts the bundle
opcode  out  6  instr[31:26]
rs, rt, rd  out  5 each  register fields; rd=0 for non-R types
shamt, funct  out  5, 6  R-type fields; 0 otherwise
imm  out  DATA_W  sign-extended instr[15:0]; 0 for R-type
reg_dest, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  control
alu_op  out  2  00 R-type, 01 BEQ/BNE, 11 LW/SW/ADDI, 00 otherwise
wr_reg  out  AW  rd when reg_dest=1, otherwise rt
rd_data_1, rd_data_2  out  DATA_W  register[rs], register[rt]
illegal  out  1  opcode not in {000000,100011,101011,000100,000101,001000,111111}
end_program  out  1  sticky; set when 111111 is accepted
wb_en  in  1  write-back strobe
wb_addr  in  AW  write-back register
wb_data  in  DATA_W  write-back value

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, out_valid=0, end_program=0, every register = 0. Reset mid-transfer drops the held bundle.
- Timing: one output register stage. Fields, controls and operands appear one cycle after the handshake (in_valid & in_ready).
- in_ready = (!out_valid | out_ready) & !stall & !end_program.
- Output hold: out_valid stays 1 and the outputs stay stable until out_ready is high.
- Register fields: rs/rt/rd use the low AW bits of the 5-bit fields. Register 0 always reads 0 and writes to it are ignored.
- Write-back: a write happens on the clock edge when wb_en=1.
- Forwarding: on an accept in the same cycle as a write, when wb_addr equals rs (or rt) and is nonzero, the operand takes wb_data.
- stall: asserted when the held bundle is valid with mem_read=1 and wr_reg!=0, and wr_reg equals rs of the incoming instruction. It also asserts when wr_reg equals rt and the incoming opcode is R-type, SW, BEQ or BNE.
- Stall release: stall clears once execute accepts the held load. The next cycle inserts a bubble (out_valid=0), and then the instruction is accepted.
- Illegal opcode: all controls 0, illegal=1, the bundle is still emitted.
- End opcode 111111: the bundle is emitted with all controls 0 and end_program set. in_ready then stays 0 until reset.
- Simultaneous out_ready and a new accept: the new bundle replaces the old one with no bubble.

Optional Feature:
DECODE_WB_BYPASS_EN.
- Defined: same-cycle write-back forwarding as above.
- Undefined: operands read the pre-write array contents, and software or the sequencer inserts the spacing.

Decomposition:
- Package decode_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_END), alu_op localparams, a packed ctrl_t struct for the seven control bits plus alu_op.
- Sub-module regfile_2r1w: parametrised by DATA_W and NUM_REGS, asynchronous active-low clear, r0 hardwired to zero.
- Bypass muxes and stall logic stay in the top level.

Test Plan:
- Reset, then write wb r5=0x0000_00AA. Accept ADDI r6,r5,-1 (0x20A6FFFF) -> imm=0xFFFFFFFF, alu_src=1, reg_write=1, alu_op=11, wr_reg=6, rd_data_1=0xAA.
- Accept R-type add r3,r1,r2 while wb_en writes r1=0x1234 in the same cycle -> with DECODE_WB_BYPASS_EN, rd_data_1=0x1234; without it, rd_data_1=0. reg_dest=1, wr_reg=3.
- Load-use: accept LW r4,0(r1), then offer ADD r7,r4,r2 -> in_ready=0 until the load is taken, then one bubble, then ADD is accepted.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Then out_ready=1 -> next bundle with no bubble.
- Accept 0xFC000000 -> end_program=1 next cycle and in_ready stays 0. Offer opcode 010000 beforehand -> illegal=1, all controls 0.
- Write r0 via wb -> reads of r0 stay 0. Assert rst_n=0 mid-stall -> out_valid=0 and all registers read 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode constants, control bundle type and opcode helpers.
package decode_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REGF_W   = 5;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned IMM_W    = 16;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_END   = 6'b111111;

  localparam logic [1:0] ALU_OP_RTYPE  = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_ADD    = 2'b11;
  localparam logic [1:0] ALU_OP_NONE   = 2'b00;

  // Control bundle handed to execute.
  typedef struct packed {
    logic       reg_dest;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  // Raw instruction fields as presented on the output.
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REGF_W-1:0]   rs;
    logic [REGF_W-1:0]   rt;
    logic [REGF_W-1:0]   rd;
    logic [REGF_W-1:0]   shamt;
    logic [FUNCT_W-1:0]  funct;
  } fields_t;

  // True for every opcode the core implements, including the end marker.
  function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_END: legal = 1'b1;
      default:                                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Main control decoder; end marker and illegal opcodes yield all zeros.
  function automatic ctrl_t decode_ctrl(input logic [OPCODE_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dest  = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_RTYPE;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.alu_op     = ALU_OP_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      OP_BEQ, OP_BNE: begin
        c.branch = 1'b1;
        c.alu_op = ALU_OP_BRANCH;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      default: c.alu_op = ALU_OP_NONE;
    endcase
    return c;
  endfunction

  // Opcodes whose rt field is a source operand (load-use hazard on rt).
  function automatic logic op_reads_rt(input logic [OPCODE_W-1:0] op);
    logic reads;
    case (op)
      OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: reads = 1'b1;
      default:                         reads = 1'b0;
    endcase
    return reads;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two combinational read ports, one clocked write port; r0 reads as zero
// and ignores writes. Asynchronous active-low clear of the whole array.
module regfile_2r1w #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     raddr1_i,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // Array storage: cleared on reset, written on the clock edge when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/decode_regfile_stage.sv
// Decode stage: parses the fetched instruction, builds the control bundle,
// reads two operands from the local register file and registers the result
// behind a valid/ready handshake. Detects load-use hazards and latches the
// end-of-program marker.
// Optional macro DECODE_WB_BYPASS_EN: forward same-cycle write-back data
// into the operands; without it the operands see pre-write array contents.
module decode_regfile_stage
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] imm,
  output logic              reg_dest,
  output logic              branch,
  output logic              mem_read,
  output logic              mem_to_reg,
  output logic              mem_write,
  output logic              alu_src,
  output logic              reg_write,
  output logic [1:0]        alu_op,
  output logic [AW-1:0]     wr_reg,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              illegal,
  output logic              end_program,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  // Incoming instruction decode (combinational).
  logic [OPCODE_W-1:0] in_op;
  logic                in_rtype;
  logic [AW-1:0]       in_rs_a;
  logic [AW-1:0]       in_rt_a;
  logic [AW-1:0]       in_rd_a;
  ctrl_t               in_ctrl;

  assign in_op    = in_instr[31:26];
  assign in_rtype = (in_op == OP_RTYPE);
  assign in_rs_a  = in_instr[21 +: AW];
  assign in_rt_a  = in_instr[16 +: AW];
  assign in_rd_a  = in_instr[11 +: AW];
  assign in_ctrl  = decode_ctrl(in_op);

  // Output-stage registers.
  logic              out_valid_q, out_valid_d;
  fields_t           fields_q, fields_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [AW-1:0]     wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              illegal_q, illegal_d;
  logic              end_program_q, end_program_d;

  // Register file operand reads.
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  regfile_2r1w #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr1_i(in_rs_a),
    .raddr2_i(in_rt_a),
    .rdata1_o(rf_rd1),
    .rdata2_o(rf_rd2),
    .we_i    (wb_en),
    .waddr_i (wb_addr),
    .wdata_i (wb_data)
  );

`ifdef DECODE_WB_BYPASS_EN
  // Same-cycle write-back forwarding; r0 is never forwarded.
  assign op1 = (wb_en && (wb_addr != '0) && (wb_addr == in_rs_a)) ? wb_data : rf_rd1;
  assign op2 = (wb_en && (wb_addr != '0) && (wb_addr == in_rt_a)) ? wb_data : rf_rd2;
`else
  assign op1 = rf_rd1;
  assign op2 = rf_rd2;
`endif

  // Load-use hazard against the bundle currently held for execute.
  logic load_held;
  logic stall;
  logic accept;

  assign load_held = out_valid_q && ctrl_q.mem_read && (wr_reg_q != '0);
  assign stall     = load_held &&
                     ((wr_reg_q == in_rs_a) ||
                      (op_reads_rt(in_op) && (wr_reg_q == in_rt_a)));
  assign in_ready  = (!out_valid_q || out_ready) && !stall && !end_program_q;
  assign accept    = in_valid && in_ready;

  // Next-state: load a new bundle on accept, otherwise drain when taken.
  always_comb begin
    out_valid_d   = out_valid_q;
    fields_d      = fields_q;
    ctrl_d        = ctrl_q;
    imm_d         = imm_q;
    wr_reg_d      = wr_reg_q;
    rd1_d         = rd1_q;
    rd2_d         = rd2_q;
    illegal_d     = illegal_q;
    end_program_d = end_program_q;

    if (accept) begin
      out_valid_d     = 1'b1;
      fields_d.opcode = in_op;
      fields_d.rs     = in_instr[25:21];
      fields_d.rt     = in_instr[20:16];
      fields_d.rd     = in_rtype ? in_instr[15:11] : 5'd0;
      fields_d.shamt  = in_rtype ? in_instr[10:6] : 5'd0;
      fields_d.funct  = in_rtype ? in_instr[5:0] : 6'd0;
      if (in_rtype) begin
        imm_d = '0;
      end else begin
        imm_d = DATA_W'($signed(in_instr[15:0]));
      end
      ctrl_d    = in_ctrl;
      wr_reg_d  = in_ctrl.reg_dest ? in_rd_a : in_rt_a;
      rd1_d     = op1;
      rd2_d     = op2;
      illegal_d = !op_is_legal(in_op);
      if (in_op == OP_END) begin
        end_program_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      fields_q      <= '0;
      ctrl_q        <= '0;
      imm_q         <= '0;
      wr_reg_q      <= '0;
      rd1_q         <= '0;
      rd2_q         <= '0;
      illegal_q     <= 1'b0;
      end_program_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      fields_q      <= fields_d;
      ctrl_q        <= ctrl_d;
      imm_q         <= imm_d;
      wr_reg_q      <= wr_reg_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      illegal_q     <= illegal_d;
      end_program_q <= end_program_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign opcode      = fields_q.opcode;
  assign rs          = fields_q.rs;
  assign rt          = fields_q.rt;
  assign rd          = fields_q.rd;
  assign shamt       = fields_q.shamt;
  assign funct       = fields_q.funct;
  assign imm         = imm_q;
  assign reg_dest    = ctrl_q.reg_dest;
  assign branch      = ctrl_q.branch;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign mem_write   = ctrl_q.mem_write;
  assign alu_src     = ctrl_q.alu_src;
  assign reg_write   = ctrl_q.reg_write;
  assign alu_op      = ctrl_q.alu_op;
  assign wr_reg      = wr_reg_q;
  assign rd_data_1   = rd1_q;
  assign rd_data_2   = rd2_q;
  assign illegal     = illegal_q;
  assign end_program = end_program_q;

endmodule
